// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit: eight selectable operations on two WIDTH-bit
// operands, results queued in a DEPTH-entry FIFO behind valid/ready handshakes.
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       op_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    output logic [WIDTH-1:0] y_out,
    output logic             zero_out,
    output logic             ones_out,
    output logic             out_valid_out,
    input  logic             out_ready_in,
    output logic [CNT_W-1:0] count_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_NAND = 3'b001,
        OP_OR   = 3'b010,
        OP_NOR  = 3'b011,
        OP_XOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOTA = 3'b110,
        OP_PASA = 3'b111
    } op_t;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             zero;
        logic             ones;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] result;
    entry_t           head;
    logic             push;
    logic             pop;

    always_comb begin
        result = '0;
        case (op_t'(op_in))
            OP_AND:  result = a_in & b_in;
            OP_NAND: result = ~(a_in & b_in);
            OP_OR:   result = a_in | b_in;
            OP_NOR:  result = ~(a_in | b_in);
            OP_XOR:  result = a_in ^ b_in;
            OP_XNOR: result = ~(a_in ^ b_in);
            OP_NOTA: result = ~a_in;
            OP_PASA: result = a_in;
            default: result = '0;
        endcase
    end

    // Ready looks only at registered occupancy, so a pop on a full queue
    // cannot admit a push in the same cycle.
    assign in_ready_out  = (occ_q < FULL_OCC);
    assign out_valid_out = (occ_q != '0);
    assign push          = in_valid_in & in_ready_out;
    assign pop           = out_valid_out & out_ready_in;

    assign head      = mem_q[rd_ptr_q];
    assign y_out     = out_valid_out ? head.y    : '0;
    assign zero_out  = out_valid_out ? head.zero : 1'b0;
    assign ones_out  = out_valid_out ? head.ones : 1'b0;
    assign count_out = cnt_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{y: result, zero: ~|result, ones: &result};
            wr_ptr_d        = wr_ptr_q + 1'b1;
            cnt_d           = cnt_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed and random traffic checked against a
// queue-based reference model; a CNT_W=4 instance shares the stimulus.
module tb_logic_unit_pipe;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] op = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic        in_ready, out_valid, zero, ones;
    logic [7:0]  y;
    logic [15:0] count;

    logic        in_ready4, out_valid4, zero4, ones4;
    logic [7:0]  y4;
    logic [3:0]  count4;

    int nassert = 0;
    int nfail   = 0;

    logic [7:0] mq[$];
    int         cnt = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .a_in(a), .b_in(b), .op_in(op),
        .in_valid_in(in_valid), .in_ready_out(in_ready), .y_out(y),
        .zero_out(zero), .ones_out(ones), .out_valid_out(out_valid),
        .out_ready_in(out_ready), .count_out(count)
    );

    logic_unit_pipe #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(4)) dut_c4 (
        .clk_in(clk), .rst_n_in(rst_n), .a_in(a), .b_in(b), .op_in(op),
        .in_valid_in(in_valid), .in_ready_out(in_ready4), .y_out(y4),
        .zero_out(zero4), .ones_out(ones4), .out_valid_out(out_valid4),
        .out_ready_in(out_ready), .count_out(count4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [7:0] ra, input logic [7:0] rb,
                                          input logic [2:0] rop);
        case (rop)
            3'd0:    return ra & rb;
            3'd1:    return ~(ra & rb);
            3'd2:    return ra | rb;
            3'd3:    return ~(ra | rb);
            3'd4:    return ra ^ rb;
            3'd5:    return ~(ra ^ rb);
            3'd6:    return ~ra;
            default: return ra;
        endcase
    endfunction

    // Called just after a rising edge: drive, check against the model, then
    // advance the model by what the next edge should do.
    task automatic cycle(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [2:0] iop, input logic ordy);
        logic       push, pop;
        logic [7:0] hy, r;
        in_valid = v; a = ia; b = ib; op = iop; out_ready = ordy;
        #1;
        hy = (mq.size() > 0) ? mq[0] : 8'h00;
        chk("in_ready",  in_ready,  mq.size() < DEPTH);
        chk("out_valid", out_valid, mq.size() > 0);
        chk("y",         y,         hy);
        chk("zero",      zero,      (mq.size() > 0) && (hy == 8'h00));
        chk("ones",      ones,      (mq.size() > 0) && (hy == 8'hFF));
        chk("count",     count,     cnt % 65536);
        chk("count4",    count4,    cnt % 16);
        push = v && (mq.size() < DEPTH);
        pop  = (mq.size() > 0) && ordy;
        r    = ref_op(ia, ib, iop);
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back(r);
            cnt++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    endtask

    logic [7:0] tbl [8];

    initial begin
        tbl[0] = 8'hC0; tbl[1] = 8'h3F; tbl[2] = 8'hFC; tbl[3] = 8'h03;
        tbl[4] = 8'h3C; tbl[5] = 8'hC3; tbl[6] = 8'h0F; tbl[7] = 8'hF0;

        // Reset state
        rst_n = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_count", count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All eight ops on F0/CC with a free-running consumer
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 8'hF0, 8'hCC, 3'(i), 1'b1);
            chk("op_table", y, tbl[i]);
        end
        chk("op_count", count, 8);
        drain();

        // Backpressure on a full queue
        cycle(1'b1, 8'h11, 8'h22, 3'd7, 1'b0);
        cycle(1'b1, 8'h33, 8'h44, 3'd7, 1'b0);
        chk("full_ready", in_ready, 0);
        cycle(1'b1, 8'h55, 8'h66, 3'd7, 1'b0);
        cycle(1'b1, 8'h55, 8'h66, 3'd7, 1'b1);
        chk("ready_after_pop", in_ready, 1);
        cycle(1'b1, 8'h55, 8'h66, 3'd7, 1'b0);
        chk("third_head", y, 8'h33);
        drain();

        // Zero / ones flags
        cycle(1'b1, 8'hFF, 8'hFF, 3'd1, 1'b0);
        chk("flag_zero_y", y, 8'h00);
        chk("flag_zero", zero, 1);
        chk("flag_zero_ones", ones, 0);
        cycle(1'b1, 8'h00, 8'h00, 3'd3, 1'b1);
        cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        chk("flag_ones_y", y, 8'hFF);
        chk("flag_ones", ones, 1);
        chk("flag_ones_zero", zero, 0);
        drain();

        // Steady streaming with one entry resident
        cycle(1'b1, 8'hA5, 8'h00, 3'd7, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'(i * 17 + 1), 8'(i), 3'(i), 1'b1);
            chk("stream_occ", out_valid, 1);
        end
        drain();

        // Asynchronous reset mid-stream
        cycle(1'b1, 8'h12, 8'h00, 3'd7, 1'b0);
        cycle(1'b1, 8'h34, 8'h00, 3'd7, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_y", y, 0);
        chk("arst_count", count, 0);
        chk("arst_in_ready", in_ready, 1);
        mq.delete();
        cnt = 0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("arst_no_accept", count, 0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        cycle(1'b1, 8'h77, 8'h00, 3'd7, 1'b0);
        chk("arst_first_out", y, 8'h77);
        drain();

        // Counter wrap on the CNT_W=4 instance
        rst_n = 1'b0; #1; mq.delete(); cnt = 0;
        @(posedge clk); #1; rst_n = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            cycle(1'b1, 8'(i), 8'h00, 3'd7, 1'b1);
            if (i == 16) chk("wrap16", count4, 0);
            if (i == 17) chk("wrap17", count4, 1);
        end
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
